// File: rtl/polar_llr_frame_loader.sv
// -----------------------------------------------------------------------------
// polar_llr_frame_loader
//
// Input stage of the SC polar decoder. Channel LLRs from the demapper are
// arithmetically right-shifted by FRAC_SHIFT, clamped symmetrically to the
// LLR RAM width and written into one of two ping-pong banks of the LLR init
// RAM. A full bank is offered to the decoder controller with
// frame_valid/frame_bank and released again by a frame_done pulse.
//
// Parameters:
//   IN_LLR_WIDTH       signed width of in_llr (assumed >= LLR_RAM_DATA_WIDTH)
//   LLR_RAM_DATA_WIDTH signed width written to the init RAM
//   CODE_LENGTH        LLRs per frame, power of 2
//   LLR_RAM_ADDR_WIDTH log2(CODE_LENGTH)+1; MSB is the bank bit
//   FRAC_SHIFT         arithmetic right shift before clamping
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-low reset
//   in_llr            signed channel LLR
//   in_valid          in_llr is valid
//   in_last           final sample of a frame
//   in_ready          loader accepts a sample this cycle
//   init_ram_wr_en    init RAM write strobe (registered)
//   init_ram_wr_addr  {bank, index}
//   init_ram_wr_data  rescaled, clamped LLR
//   frame_valid       a full bank is ready for decoding
//   frame_bank        bank to decode
//   frame_done        one-cycle pulse: decoding of frame_bank finished
//   frame_err         one-cycle pulse on a framing error
//   sat_count         saturation event counter (only with the macro below)
//
// Build option:
//   POLAR_LLR_SAT_COUNT_EN  adds the 16-bit saturating sat_count port/counter.
// -----------------------------------------------------------------------------
module polar_llr_frame_loader #(
    parameter int IN_LLR_WIDTH       = 12,
    parameter int LLR_RAM_DATA_WIDTH = 8,
    parameter int CODE_LENGTH        = 1024,
    parameter int LLR_RAM_ADDR_WIDTH = 11,
    parameter int FRAC_SHIFT         = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic signed [IN_LLR_WIDTH-1:0]       in_llr,
    input  logic                                 in_valid,
    input  logic                                 in_last,
    output logic                                 in_ready,
    output logic                                 init_ram_wr_en,
    output logic        [LLR_RAM_ADDR_WIDTH-1:0] init_ram_wr_addr,
    output logic        [LLR_RAM_DATA_WIDTH-1:0] init_ram_wr_data,
    output logic                                 frame_valid,
    output logic                                 frame_bank,
    input  logic                                 frame_done,
    output logic                                 frame_err
`ifdef POLAR_LLR_SAT_COUNT_EN
    ,
    output logic        [15:0]                   sat_count
`endif
);

    localparam int IDX_W = LLR_RAM_ADDR_WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LENGTH - 1);

    // Symmetric clamp limits: the most negative code is never produced.
    localparam logic signed [IN_LLR_WIDTH-1:0] POS_LIM =
        IN_LLR_WIDTH'((2 ** (LLR_RAM_DATA_WIDTH - 1)) - 1);
    localparam logic signed [IN_LLR_WIDTH-1:0] NEG_LIM = -POS_LIM;
    localparam logic [LLR_RAM_DATA_WIDTH-1:0] POS_OUT =
        {1'b0, {(LLR_RAM_DATA_WIDTH - 1){1'b1}}};
    localparam logic [LLR_RAM_DATA_WIDTH-1:0] NEG_OUT =
        {1'b1, {(LLR_RAM_DATA_WIDTH - 2){1'b0}}, 1'b1};

    // Writer state: LOAD accepts samples, COMMIT is the single bubble cycle
    // after a final accept in which the written bank is marked full.
    typedef enum logic {
        WR_LOAD,
        WR_COMMIT
    } wr_state_t;

    wr_state_t wr_state;
    wr_state_t wr_state_next;

    logic             commit_pend;
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       full;
    logic [1:0]       full_next;
    logic             rd_bank;

    logic                                 accept;
    logic                                 last_idx;
    logic                                 done_take;
    logic signed [IN_LLR_WIDTH-1:0]       shifted;
    logic                                 sat_hi;
    logic                                 sat_lo;
    logic        [LLR_RAM_DATA_WIDTH-1:0] scaled;

    // -------------------------------------------------------------------------
    // Writer FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_state <= WR_LOAD;
        end else begin
            wr_state <= wr_state_next;
        end
    end

    // Writer FSM: next state
    always_comb begin
        wr_state_next = wr_state;
        unique case (wr_state)
            WR_LOAD:   if (accept && last_idx) wr_state_next = WR_COMMIT;
            WR_COMMIT: wr_state_next = WR_LOAD;
            default:   wr_state_next = WR_LOAD;
        endcase
    end

    // Writer FSM: outputs
    always_comb begin
        commit_pend = (wr_state == WR_COMMIT);
        in_ready    = !full[wr_bank] && !commit_pend;
    end

    // -------------------------------------------------------------------------
    // Accept and rescale
    // -------------------------------------------------------------------------
    assign accept    = in_valid && in_ready;
    assign last_idx  = (wr_idx == LAST_IDX);
    assign done_take = frame_done && full[rd_bank];

    always_comb begin
        shifted = in_llr >>> FRAC_SHIFT;
        sat_hi  = (shifted > POS_LIM);
        sat_lo  = (shifted < NEG_LIM);
        if (sat_hi) begin
            scaled = POS_OUT;
        end else if (sat_lo) begin
            scaled = NEG_OUT;
        end else begin
            scaled = shifted[LLR_RAM_DATA_WIDTH-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Registered RAM write port and framing-error pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_ram_wr_en   <= 1'b0;
            init_ram_wr_addr <= '0;
            init_ram_wr_data <= '0;
            frame_err        <= 1'b0;
        end else begin
            init_ram_wr_en <= accept;
            if (accept) begin
                init_ram_wr_addr <= {wr_bank, wr_idx};
                init_ram_wr_data <= scaled;
            end
            // Error when in_last disagrees with the frame position.
            frame_err <= accept && (last_idx ? !in_last : in_last);
        end
    end

    // -------------------------------------------------------------------------
    // Write index and bank
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else begin
            if (accept) begin
                // Early in_last drops the partial frame; it is overwritten.
                if (last_idx || in_last) begin
                    wr_idx <= '0;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (commit_pend) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Bank full flags and read side. A commit and a frame_done in the same
    // cycle always address different banks, so both updates apply.
    // -------------------------------------------------------------------------
    always_comb begin
        full_next = full;
        if (commit_pend) begin
            full_next[wr_bank] = 1'b1;
        end
        if (done_take) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full    <= 2'b00;
            rd_bank <= 1'b0;
        end else begin
            full <= full_next;
            if (done_take) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    assign frame_valid = full[rd_bank];
    assign frame_bank  = rd_bank;

`ifdef POLAR_LLR_SAT_COUNT_EN
    // -------------------------------------------------------------------------
    // Saturation counter: sticks at all-ones, cleared only by reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_count <= '0;
        end else if (accept && (sat_hi || sat_lo) && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_polar_llr_frame_loader.sv
module tb_polar_llr_frame_loader;

    localparam int IN_W = 12;
    localparam int D_W  = 8;
    localparam int N    = 1024;
    localparam int A_W  = 11;
    localparam int FRAC = 2;
    localparam int LIM  = 127;

    logic                   clk = 1'b0;
    logic                   reset;
    logic signed [IN_W-1:0] in_llr;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic                   init_ram_wr_en;
    logic        [A_W-1:0]  init_ram_wr_addr;
    logic        [D_W-1:0]  init_ram_wr_data;
    logic                   frame_valid;
    logic                   frame_bank;
    logic                   frame_done;
    logic                   frame_err;
`ifdef POLAR_LLR_SAT_COUNT_EN
    logic        [15:0]     sat_count;
`endif

    always #5 clk = ~clk;

    polar_llr_frame_loader #(
        .IN_LLR_WIDTH       (IN_W),
        .LLR_RAM_DATA_WIDTH (D_W),
        .CODE_LENGTH        (N),
        .LLR_RAM_ADDR_WIDTH (A_W),
        .FRAC_SHIFT         (FRAC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_llr           (in_llr),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .init_ram_wr_en   (init_ram_wr_en),
        .init_ram_wr_addr (init_ram_wr_addr),
        .init_ram_wr_data (init_ram_wr_data),
        .frame_valid      (frame_valid),
        .frame_bank       (frame_bank),
        .frame_done       (frame_done),
        .frame_err        (frame_err)
`ifdef POLAR_LLR_SAT_COUNT_EN
        ,
        .sat_count        (sat_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Observed write / error activity
    int got_addr[$];
    int got_data[$];
    int got_err = 0;

    // Reference model: expected writes, frame bookkeeping
    int exp_addr[$];
    int exp_data[$];
    int exp_err = 0;
    int m_wr_bank = 0;
    int m_idx = 0;
    int m_rd_bank = 0;
    int m_pend_q[$];
    int m_sat = 0;

    int stim[$];
    int last_pos;

    always @(negedge clk) begin
        if (init_ram_wr_en === 1'b1) begin
            got_addr.push_back(int'(init_ram_wr_addr));
            got_data.push_back(int'(signed'(init_ram_wr_data)));
        end
        if (frame_err === 1'b1) got_err++;
    end

    // Frame-level model of one accepted sample.
    task automatic model_accept(input int v, input bit last);
        int s;
        s = v >>> FRAC;
        if ((s > LIM || s < -LIM) && m_sat < 65535) m_sat++;
        if (s > LIM) s = LIM;
        if (s < -LIM) s = -LIM;
        exp_addr.push_back(m_wr_bank * N + m_idx);
        exp_data.push_back(s);
        if (m_idx == N - 1) begin
            if (!last) exp_err++;
            m_pend_q.push_back(m_wr_bank);
            m_wr_bank ^= 1;
            m_idx = 0;
        end else if (last) begin
            exp_err++;
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    function automatic bit exp_ready();
        foreach (m_pend_q[i]) if (m_pend_q[i] == m_wr_bank) return 1'b0;
        return 1'b1;
    endfunction

    // Streams stim[]; returns #1 after the edge that accepted the last entry.
    task automatic drive_stim();
        int guard;
        for (int i = 0; i < stim.size(); i++) begin
            in_llr   = IN_W'(stim[i]);
            in_last  = (i == last_pos);
            in_valid = 1'b1;
            guard = 0;
            while (in_ready !== 1'b1 && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
            if (in_ready !== 1'b1) begin
                checks++; errors++;
                $display("FAIL ready_timeout got in_ready=%b need 1", in_ready);
                in_valid = 1'b0; in_last = 1'b0;
                stim.delete();
                return;
            end
            @(posedge clk); #1;
            model_accept(stim[i], i == last_pos);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        stim.delete();
    endtask

    task automatic fill_random(input int n);
        repeat (n) stim.push_back(int'($urandom_range(0, 4095)) - 2048);
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
        if (m_pend_q.size() > 0) begin
            void'(m_pend_q.pop_front());
            m_rd_bank ^= 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_llr = '0; in_valid = 1'b0; in_last = 1'b0; frame_done = 1'b0;
        #22 reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (init_ram_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b exp=0", init_ram_wr_en); end
        checks++; if (init_ram_wr_addr !== '0) begin errors++; $display("FAIL rst_wr_addr got=%0d exp=0", init_ram_wr_addr); end
        checks++; if (init_ram_wr_data !== '0) begin errors++; $display("FAIL rst_wr_data got=%0d exp=0", init_ram_wr_data); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_frame_valid got=%b exp=0", frame_valid); end
        checks++; if (frame_bank !== 1'b0) begin errors++; $display("FAIL rst_frame_bank got=%b exp=0", frame_bank); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
`ifdef POLAR_LLR_SAT_COUNT_EN
        checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL rst_sat_count got=%0d exp=0", sat_count); end
`endif
    endtask

    task automatic test_basic_frame();
        repeat (N) stim.push_back(20);
        last_pos = N - 1;
        drive_stim();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_bubble got in_ready=%b exp=0", in_ready); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_k1 got=%b exp=0", frame_valid); end
        @(posedge clk); #1;
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_k2 got=%b exp=1", frame_valid); end
        checks++; if (frame_bank !== 1'(m_rd_bank)) begin errors++; $display("FAIL basic_bank got=%b exp=%0d", frame_bank, m_rd_bank); end
        checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL basic_ready got=%b exp=%b", in_ready, exp_ready()); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin errors++; $display("FAIL basic_wr_count got=%0d exp=%0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL basic_wr[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
        checks++; if (got_err !== exp_err) begin errors++; $display("FAIL basic_err_count got=%0d exp=%0d", got_err, exp_err); end
    endtask

    task automatic test_saturation();
        stim.push_back(2047); stim.push_back(-2048); stim.push_back(-4);
        last_pos = -1;
        drive_stim();
`ifdef POLAR_LLR_SAT_COUNT_EN
        checks++; if (sat_count !== 16'(m_sat)) begin errors++; $display("FAIL sat_count_3 got=%0d exp=%0d", sat_count, m_sat); end
`endif
        fill_random(N - 3);
        last_pos = N - 4;
        drive_stim();
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sat_both_full got in_ready=%b exp=0", in_ready); end
        checks++; if (frame_bank !== 1'(m_rd_bank)) begin errors++; $display("FAIL sat_bank got=%b exp=%0d", frame_bank, m_rd_bank); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin errors++; $display("FAIL sat_wr_count got=%0d exp=%0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL sat_wr[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
`ifdef POLAR_LLR_SAT_COUNT_EN
        checks++; if (sat_count !== 16'(m_sat)) begin errors++; $display("FAIL sat_count_frame got=%0d exp=%0d", sat_count, m_sat); end
`endif
    endtask

    task automatic test_back_to_back();
        in_llr = 12'sd100; in_valid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got in_ready=%b exp=0", in_ready); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (got_addr.size() != 0) begin errors++; $display("FAIL b2b_stall_writes got=%0d exp=0", got_addr.size()); end
        pulse_done();
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", frame_valid); end
        checks++; if (frame_bank !== 1'(m_rd_bank)) begin errors++; $display("FAIL b2b_bank got=%b exp=%0d", frame_bank, m_rd_bank); end
        checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL b2b_ready got=%b exp=%b", in_ready, exp_ready()); end
        fill_random(N);
        last_pos = N - 1;
        drive_stim();
        @(posedge clk); #1;
        checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL b2b_ready3 got=%b exp=%b", in_ready, exp_ready()); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin errors++; $display("FAIL b2b_wr_count got=%0d exp=%0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL b2b_wr[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
        pulse_done();
        checks++; if (frame_bank !== 1'(m_rd_bank)) begin errors++; $display("FAIL b2b_drain_bank got=%b exp=%0d", frame_bank, m_rd_bank); end
        pulse_done();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid got=%b exp=0", frame_valid); end
    endtask

    task automatic test_early_last();
        fill_random(100);
        last_pos = 99;
        drive_stim();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_err_pulse got=%b exp=1", frame_err); end
        @(posedge clk); #1;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL early_err_width got=%b exp=0", frame_err); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL early_no_commit got=%b exp=0", frame_valid); end
        fill_random(N);
        last_pos = N - 1;
        drive_stim();
        @(posedge clk); #1;
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL early_next_valid got=%b exp=1", frame_valid); end
        checks++; if (frame_bank !== 1'(m_rd_bank)) begin errors++; $display("FAIL early_next_bank got=%b exp=%0d", frame_bank, m_rd_bank); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin errors++; $display("FAIL early_wr_count got=%0d exp=%0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL early_wr[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
        checks++; if (got_err !== exp_err) begin errors++; $display("FAIL early_err_count got=%0d exp=%0d", got_err, exp_err); end
    endtask

    task automatic test_missing_last();
        pulse_done();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL miss_drain got=%b exp=0", frame_valid); end
        pulse_done();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL idle_done_valid got=%b exp=0", frame_valid); end
        checks++; if (frame_bank !== 1'(m_rd_bank)) begin errors++; $display("FAIL idle_done_bank got=%b exp=%0d", frame_bank, m_rd_bank); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_done_ready got=%b exp=1", in_ready); end
        fill_random(N);
        last_pos = -1;
        drive_stim();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL miss_err_pulse got=%b exp=1", frame_err); end
        @(posedge clk); #1;
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL miss_valid got=%b exp=1", frame_valid); end
        checks++; if (frame_bank !== 1'(m_rd_bank)) begin errors++; $display("FAIL miss_bank got=%b exp=%0d", frame_bank, m_rd_bank); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin errors++; $display("FAIL miss_wr_count got=%0d exp=%0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL miss_wr[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
        checks++; if (got_err !== exp_err) begin errors++; $display("FAIL miss_err_count got=%0d exp=%0d", got_err, exp_err); end
    endtask

    task automatic test_reset_mid_frame();
        fill_random(500);
        last_pos = -1;
        drive_stim();
        @(negedge clk); #1;
        checks++;
        if (got_addr.size() != exp_addr.size()) begin errors++; $display("FAIL mid_wr_count got=%0d exp=%0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL mid_wr[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
        reset = 1'b0;
        #1;
        checks++; if (init_ram_wr_addr !== '0) begin errors++; $display("FAIL mid_rst_addr got=%0d exp=0", init_ram_wr_addr); end
        checks++; if (init_ram_wr_data !== '0) begin errors++; $display("FAIL mid_rst_data got=%0d exp=0", init_ram_wr_data); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", frame_valid); end
        checks++; if (frame_bank !== 1'b0) begin errors++; $display("FAIL mid_rst_bank got=%b exp=0", frame_bank); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", in_ready); end
`ifdef POLAR_LLR_SAT_COUNT_EN
        checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL mid_rst_sat got=%0d exp=0", sat_count); end
`endif
        @(posedge clk); #1;
        checks++; if (init_ram_wr_en !== 1'b0) begin errors++; $display("FAIL mid_rst_wr_en got=%b exp=0", init_ram_wr_en); end
        @(negedge clk);
        reset = 1'b1;
        m_wr_bank = 0; m_idx = 0; m_rd_bank = 0; m_sat = 0;
        m_pend_q.delete();
        got_addr.delete(); got_data.delete();
        fill_random(N);
        last_pos = N - 1;
        drive_stim();
        @(posedge clk); #1;
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got=%b exp=1", frame_valid); end
        checks++; if (frame_bank !== 1'b0) begin errors++; $display("FAIL post_rst_bank got=%b exp=0", frame_bank); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin errors++; $display("FAIL post_rst_wr_count got=%0d exp=%0d", got_addr.size(), exp_addr.size()); end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL post_rst_wr[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
`ifdef POLAR_LLR_SAT_COUNT_EN
        checks++; if (sat_count !== 16'(m_sat)) begin errors++; $display("FAIL post_rst_sat got=%0d exp=%0d", sat_count, m_sat); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_saturation();
        test_back_to_back();
        test_early_last();
        test_missing_last();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout need completion");
        $fatal(1);
    end

endmodule
